// File: rtl/mbist_fail_logger.sv
// MBIST fail logger: counts compare mismatches and logs them in a show-ahead FIFO.
// Optional macro MBIST_FAIL_BITMAP_EN enables the accumulated FAIL_BITS register.
module mbist_fail_logger #(
  parameter int DEPTH = 8,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CMP_VALID,
  input  logic [AW-1:0] CMP_ADDR,
  input  logic [DW-1:0] CMP_EXP,
  input  logic [DW-1:0] CMP_ACT,
  input  logic          CLEAR,
  input  logic          LOG_RD,
  output logic          LOG_VALID,
  output logic [AW-1:0] LOG_ADDR,
  output logic [DW-1:0] LOG_EXP,
  output logic [DW-1:0] LOG_ACT,
  output logic [7:0]    FAIL_CNT,
  output logic          FAIL,
  output logic          OVERFLOW,
  output logic [DW-1:0] FAIL_BITS
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            EW      = AW + 2 * DW;
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);

  // Handshake: an entry leaves the FIFO on a rising edge where LOG_RD=1 and
  // LOG_VALID=1; LOG_RD while LOG_VALID=0 is ignored. There is no back-pressure
  // on CMP_VALID: a mismatch arriving while full (and not popping) is dropped.

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    fail_cnt_q, fail_cnt_d;
  logic          fail_q, fail_d;
  logic          overflow_q, overflow_d;

  logic          mismatch;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          wr_en;
  logic [EW-1:0] head;

  assign mismatch = CMP_VALID && (CMP_EXP != CMP_ACT);
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign pop      = LOG_RD && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push     = mismatch && (!full || pop);
  assign wr_en    = push && !RESET && !CLEAR;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fail_cnt_d = fail_cnt_q;
    fail_d     = fail_q;
    overflow_d = overflow_q;
    if (CLEAR) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fail_cnt_d = '0;
      fail_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PW + 1)'(1);
        2'b01:   count_d = count_q - (PW + 1)'(1);
        default: count_d = count_q;
      endcase
      if (mismatch) begin
        fail_d = 1'b1;
        if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
        if (!push) overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fail_cnt_q <= '0;
      fail_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fail_cnt_q <= fail_cnt_d;
      fail_q     <= fail_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: LOG_* are gated by LOG_VALID.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= {CMP_ADDR, CMP_EXP, CMP_ACT};
  end

`ifdef MBIST_FAIL_BITMAP_EN
  logic [DW-1:0] fail_bits_q, fail_bits_d;

  always_comb begin
    fail_bits_d = fail_bits_q;
    if (CLEAR)         fail_bits_d = '0;
    else if (mismatch) fail_bits_d = fail_bits_q | (CMP_EXP ^ CMP_ACT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) fail_bits_q <= '0;
    else       fail_bits_q <= fail_bits_d;
  end

  assign FAIL_BITS = fail_bits_q;
`else
  assign FAIL_BITS = '0;
`endif

  assign head      = mem_q[rd_ptr_q];
  assign LOG_VALID = !empty;
  assign LOG_ADDR  = LOG_VALID ? head[EW-1 -: AW]     : '0;
  assign LOG_EXP   = LOG_VALID ? head[2*DW-1 -: DW]   : '0;
  assign LOG_ACT   = LOG_VALID ? head[DW-1:0]         : '0;
  assign FAIL_CNT  = fail_cnt_q;
  assign FAIL      = fail_q;
  assign OVERFLOW  = overflow_q;

  a_count_bound: assert property (@(posedge CLK) disable iff (RESET) count_q <= DEPTH_C);
  a_fail_follows_cnt: assert property (@(posedge CLK) disable iff (RESET) (fail_cnt_q != 8'd0) == fail_q);

endmodule

// File: tb/tb_mbist_fail_logger.sv
// Bench for mbist_fail_logger: directed scenarios plus random traffic against a queue-based
// reference model; popped entries are checked by a monitor against an expected queue.
module tb_mbist_fail_logger;

  localparam int DEPTH = 8;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int W     = AW + 2 * DW;

  logic          clk;
  logic          rst;
  logic          cmp_valid;
  logic [AW-1:0] cmp_addr;
  logic [DW-1:0] cmp_exp;
  logic [DW-1:0] cmp_act;
  logic          clr;
  logic          log_rd;
  logic          log_valid;
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_exp;
  logic [DW-1:0] log_act;
  logic [7:0]    fail_cnt;
  logic          fail;
  logic          overflow;
  logic [DW-1:0] fail_bits;

  mbist_fail_logger #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(clk), .RESET(rst), .CMP_VALID(cmp_valid), .CMP_ADDR(cmp_addr),
    .CMP_EXP(cmp_exp), .CMP_ACT(cmp_act), .CLEAR(clr), .LOG_RD(log_rd),
    .LOG_VALID(log_valid), .LOG_ADDR(log_addr), .LOG_EXP(log_exp), .LOG_ACT(log_act),
    .FAIL_CNT(fail_cnt), .FAIL(fail), .OVERFLOW(overflow), .FAIL_BITS(fail_bits)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [W-1:0]  ref_q[$];
  logic [W-1:0]  exp_q[$];
  int            ref_cnt;
  bit            ref_fail;
  bit            ref_ovf;
  logic [DW-1:0] ref_bits;
  bit            model_live = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0]  h;
    logic [DW-1:0] eb;
    h = (ref_q.size() != 0) ? ref_q[0] : '0;
`ifdef MBIST_FAIL_BITMAP_EN
    eb = ref_bits;
`else
    eb = '0;
`endif
    chk("log_valid", 32'(log_valid), 32'(ref_q.size() != 0));
    chk("log_addr",  32'(log_addr),  32'(h[W-1 -: AW]));
    chk("log_exp",   32'(log_exp),   32'(h[2*DW-1 -: DW]));
    chk("log_act",   32'(log_act),   32'(h[DW-1:0]));
    chk("fail_cnt",  32'(fail_cnt),  32'(ref_cnt));
    chk("fail",      32'(fail),      32'(ref_fail));
    chk("overflow",  32'(overflow),  32'(ref_ovf));
    chk("fail_bits", 32'(fail_bits), 32'(eb));
  endtask

  // Applies one cycle of stimulus and advances the model to the state after the next edge.
  task automatic cyc(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] e,
                     input logic [DW-1:0] a, input logic c, input logic rd, input logic r);
    @(negedge clk);
    if (model_live) check_outputs();
    cmp_valid = v; cmp_addr = ad; cmp_exp = e; cmp_act = a;
    clr = c; log_rd = rd; rst = r;
    if (r || c) begin
      ref_q.delete();
      ref_cnt = 0; ref_fail = 0; ref_ovf = 0; ref_bits = '0;
      model_live = 1;
    end else begin
      if (rd && ref_q.size() != 0) exp_q.push_back(ref_q.pop_front());
      if (v && (e != a)) begin
        ref_cnt  = (ref_cnt < 255) ? ref_cnt + 1 : 255;
        ref_fail = 1;
        ref_bits = ref_bits | (e ^ a);
        if (ref_q.size() < DEPTH) ref_q.push_back({ad, e, a});
        else ref_ovf = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic miss(input logic [AW-1:0] ad, input logic rd);
    cyc(1, ad, DW'(ad), ~DW'(ad), 0, rd, 0);
  endtask

  // monitor: samples just before the active edge, after the driver has settled
  always begin
    @(negedge clk);
    #2;
    if (!rst && !clr && log_rd && log_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pop_entry: got 0x%0h expected none (t=%0t)", {log_addr, log_exp, log_act}, $time);
      end else begin
        chk("pop_entry", 32'({log_addr, log_exp, log_act}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    cmp_valid = 0; cmp_addr = '0; cmp_exp = '0; cmp_act = '0;
    clr = 0; log_rd = 0; rst = 1;

    // reset held two cycles with a live mismatch on the compare port
    cyc(1, 8'h00, 8'h55, 8'h54, 0, 0, 1);
    cyc(1, 8'h00, 8'h55, 8'h54, 0, 0, 1);
    idle(1);

    // single fail, then pop it
    cyc(1, 8'h12, 8'hAA, 8'hAB, 0, 0, 0);
    idle(1);
    cyc(0, '0, '0, '0, 0, 1, 0);
    idle(1);

    // pass filtering
    cyc(0, '0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 8'h5A, 8'h5A, 0, 0, 0);
    idle(1);

    // fill past full, then drain in order
    for (int i = 0; i < 10; i++) miss(8'(i), 0);
    idle(1);
    for (int i = 0; i < 8; i++) cyc(0, '0, '0, '0, 0, 1, 0);
    cyc(0, '0, '0, '0, 0, 1, 0);
    idle(1);

    // push and pop together while full
    cyc(0, '0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 8; i++) miss(8'h30 + 8'(i), 0);
    miss(8'h40, 1);
    idle(1);
    for (int i = 0; i < 8; i++) cyc(0, '0, '0, '0, 0, 1, 0);
    idle(1);

    // counter saturation, then clear racing a mismatch
    for (int i = 0; i < 300; i++) miss(8'(i), 0);
    idle(1);
    cyc(1, 8'h77, 8'h0F, 8'hF0, 1, 1, 0);
    idle(2);

    // random traffic with occasional clear / reset
    for (int i = 0; i < 2000; i++) begin
      logic [DW-1:0] e;
      logic [DW-1:0] a;
      e = DW'($urandom);
      a = ($urandom_range(0, 2) == 0) ? e : DW'($urandom);
      cyc(1'($urandom_range(0, 1)), AW'($urandom), e, a,
          $urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0);
    end
    idle(1);
    while (ref_q.size() != 0) cyc(0, '0, '0, '0, 0, 1, 0);
    idle(2);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mbist_fail_logger.md
MBIST_FAIL_LOGGER -- requirements
Module: mbist_fail_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 8, fail-log FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter AW, default 8, address width.
REQ-003 SHALL have parameter DW, default 8, data width.
REQ-004 SHALL have port CLK  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port RESET  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port CMP_VALID  in  1  compare strobe from MBIST controller; read data valid this cycle.
REQ-007 SHALL have port CMP_ADDR  in  AW  address of the compared word.
REQ-008 SHALL have port CMP_EXP  in  DW  expected data.
REQ-009 SHALL have port CMP_ACT  in  DW  data read from memory (DATA_DUT).
REQ-010 SHALL have port CLEAR  in  1  synchronous log clear.
REQ-011 SHALL have port LOG_RD  in  1  pop request from host.
REQ-012 SHALL have port LOG_VALID  out  1  FIFO non-empty; LOG_ADDR/LOG_EXP/LOG_ACT hold the head entry.
REQ-013 SHALL have ports LOG_ADDR  out  AW, LOG_EXP  out  DW and LOG_ACT  out  DW; head entry fields.
REQ-014 SHALL have port FAIL_CNT  out  8  total mismatches, saturating.
REQ-015 SHALL have port FAIL  out  1  sticky: at least one mismatch since clear.
REQ-016 SHALL have port OVERFLOW  out  1  sticky: a mismatch was dropped because the FIFO was full.
REQ-017 SHALL have port FAIL_BITS  out  DW  accumulated failing bit positions (see Configuration).

Function
REQ-018 SHALL define mismatch = CMP_VALID and (CMP_EXP != CMP_ACT); CMP_VALID with equal data SHALL have no effect.
REQ-019 SHALL push {CMP_ADDR, CMP_EXP, CMP_ACT} into the FIFO on a mismatch when not full.
REQ-020 SHALL be show-ahead: an entry pushed into an empty FIFO at edge N appears on LOG_* with LOG_VALID=1 after edge N (1-cycle latency).
REQ-021 SHALL pop the head on a rising edge where LOG_RD=1 and LOG_VALID=1; LOG_RD with LOG_VALID=0 SHALL be ignored with no pointer change.
REQ-022 SHALL, on simultaneous push and pop, accept both and leave occupancy unchanged, including when full.
REQ-023 SHALL, on a mismatch while full with no same-cycle pop, drop the entry, set OVERFLOW, and leave FIFO contents unchanged.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; occupancy SHALL be tracked with a count 0..DEPTH to distinguish full from empty.
REQ-025 SHALL increment FAIL_CNT by 1 on every mismatch, independent of FIFO state, saturating at 255 (no wrap).
REQ-026 SHALL set FAIL on the edge that registers the first mismatch; FAIL and FAIL_CNT SHALL be visible the cycle after.
REQ-027 SHALL, on CLEAR=1, empty the FIFO and zero FAIL_CNT, FAIL, OVERFLOW and FAIL_BITS; CLEAR SHALL take priority over a same-cycle mismatch or pop, which are discarded.
REQ-028 SHALL drive LOG_ADDR/LOG_EXP/LOG_ACT to 0 whenever LOG_VALID=0.

Reset
REQ-029 SHALL, with RESET=1 at a rising edge, perform the CLEAR action; after reset LOG_VALID=0, LOG_*=0, FAIL_CNT=0, FAIL=0, OVERFLOW=0, FAIL_BITS=0.
REQ-030 SHALL give RESET priority over CLEAR, CMP_VALID and LOG_RD; reset mid-operation SHALL discard all logged entries.

Configuration
REQ-031 SHALL, with macro MBIST_FAIL_BITMAP_EN defined, update FAIL_BITS on each mismatch as FAIL_BITS | (CMP_EXP ^ CMP_ACT), independent of FIFO full.
REQ-032 SHALL, without MBIST_FAIL_BITMAP_EN, tie FAIL_BITS to 0 and instantiate no bitmap register; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL verify reset: RESET=1 for 2 cycles with CMP_VALID=1, EXP=0x55, ACT=0x54 -> all outputs 0 after release.
REQ-034 SHALL verify single fail: CMP_VALID=1, ADDR=0x12, EXP=0xAA, ACT=0xAB for one cycle -> next cycle LOG_VALID=1, LOG_ADDR=0x12, LOG_EXP=0xAA, LOG_ACT=0xAB, FAIL_CNT=1, FAIL=1, FAIL_BITS=0x01 (macro on) / 0x00 (off); LOG_RD one cycle -> LOG_VALID=0.
REQ-035 SHALL verify pass filtering: 16 strobes with EXP=ACT=0x5A -> LOG_VALID=0, FAIL_CNT=0, FAIL=0.
REQ-036 SHALL verify full/overflow: 10 consecutive mismatches at ADDR 0..9, DEPTH=8, no reads -> FAIL_CNT=10, OVERFLOW=1; draining 8 pops returns ADDR 0..7 in order, then LOG_VALID=0.
REQ-037 SHALL verify push+pop when full: FIFO full, mismatch ADDR=0x40 with LOG_RD=1 -> OVERFLOW stays 0, occupancy 8, 0x40 is the last entry drained.
REQ-038 SHALL verify saturation and clear: 300 mismatches -> FAIL_CNT=255; CLEAR=1 concurrent with a mismatch -> all outputs 0 next cycle.
